spi_reg_bank: RTL and testbench
===============================

# spi_reg_bank

Parametrised SPI (mode 0) peripheral exposing a bank of `NUM_REGS` host-writable, host-readable configuration registers to the rest of the chip (output enables, PWM enables, duty cycle). All SPI pins are treated as asynchronous inputs: they are synchronised and edge-detected in the system clock domain, and no logic is clocked by `sclk`. This block replaces the fixed write-only five-register decoder. It adds:
- read-back on `cipo`
- frame-length and address validation
- a one-cycle write strobe for downstream consumers

## Interface
- `ADDR_W`, default 7: address field width.
- `DATA_W`, default 8: register width.
- `NUM_REGS`, default 5: implemented registers, addresses 0..NUM_REGS-1.
- `SYNC_STAGES`, default 2: flip-flops per input synchroniser (≥2).
- `clk`  in  1  system clock; one clock for the whole block.
- `rst_n`  in  1  reset; asynchronous assertion, active-low.
- `sclk`  in  1  SPI clock (asynchronous pin).
- `ncs`  in  1  SPI chip select, active-low (asynchronous pin).
- `copi`  in  1  controller-out data (asynchronous pin).
- `cipo`  out  1  peripheral-out data.
- `cipo_oe`  out  1  output enable for `cipo` pad.
- `regs`  out  NUM_REGS*DATA_W  flattened register bank; reg k occupies bits [k*DATA_W +: DATA_W].
- `wr_strobe`  out  1  one-cycle pulse when a register is committed.
- `wr_addr`  out  ADDR_W  address of the last committed write, valid with `wr_strobe`.
- `frame_err`  out  1  one-cycle pulse when a frame is rejected.

## Operation
- Frame, MSB first, `FRAME_W = 1+ADDR_W+DATA_W` bits: the R/W bit (1 = write, 0 = read), then the address, then the data. Default frame length is 16.
- `copi` is sampled on synchronised `sclk` rising edges only while synchronised `ncs` is low. Edges are ignored while `ncs` is high.
- A falling edge on `ncs` starts a frame and clears the bit counter and shift register.
- The bit counter saturates at FRAME_W+1, so overlength frames are detected.
- States:
  - IDLE → CMD on `ncs` fall.
  - CMD → DATA after bit 1+ADDR_W.
  - DATA → IDLE on `ncs` rise.
  - Any state → IDLE on `ncs` rise.
- Write commit:
  - Condition: on `ncs` rise, R/W=1, count == FRAME_W and address < NUM_REGS.
  - Action: the register is loaded, and `wr_strobe` and `wr_addr` are set.
- Frame rejection:
  - Condition: on `ncs` rise, count != FRAME_W (count 0 excluded), or address ≥ NUM_REGS.
  - Action: `frame_err` pulses and no register changes.
  - This applies to both reads and writes.
- Read path:
  - Entering DATA with R/W=0 loads the addressed register into the output shift register.
  - An out-of-range address loads 0.
  - MSB is presented on `cipo`, and `cipo_oe` goes to 1.
  - Each subsequent synchronised `sclk` falling edge shifts the next bit.
  - `cipo_oe` = 0 outside the DATA phase of a read frame, and `cipo` = 0 whenever `cipo_oe` = 0.
- Simultaneous `sclk` edge and `ncs` rise in the same sample: `ncs` wins and the edge is discarded.
- Reset mid-frame: the frame is aborted, the FSM returns to IDLE, and there is no strobe or error.
- Reset values: all `regs` 0, `cipo` 0, `cipo_oe` 0, `wr_strobe` 0, `wr_addr` 0, `frame_err` 0.

## Timing
- Input synchronisation to edge-detect: SYNC_STAGES+1 `clk` edges from pin change.
- Write visibility: `regs` and `wr_strobe` update on the `clk` edge after the synchronised `ncs` rise is detected, i.e. SYNC_STAGES+2 cycles after the pin edge. `wr_strobe` is high for exactly one cycle.
- `frame_err` has the same timing as `wr_strobe`. The two never assert together.
- `cipo` valid SYNC_STAGES+2 cycles after the `sclk` falling pin edge. This requires `sclk` high and low phases each ≥ SYNC_STAGES+3 `clk` periods (f_sclk ≤ f_clk/10 at default).
- Minimum `ncs` high time between frames: SYNC_STAGES+2 `clk` periods.

## Structure
- Package `spi_reg_pkg`:
  - FSM state encoding (IDLE, CMD, DATA)
  - `RW_WRITE`/`RW_READ` constants
  - function computing FRAME_W and the counter width (clog2(FRAME_W+2))
- Sub-module `spi_sync_edge`: SYNC_STAGES-flop synchroniser plus registered previous value, with outputs `level`, `rise`, `fall`. It is instantiated for `sclk`, `ncs` and `copi` (`copi` uses `level` only).

## Test plan
- Write 0xA5 to addr 4 (frame 0x84A5) → `regs[39:32]`=0xA5, single `wr_strobe` with `wr_addr`=4, `frame_err` stays 0.
- Write 0x3C to addr 2, then read addr 2 (frame 0x02xx) → `cipo` bits 0,0,1,1,1,1,0,0 on data-phase rising edges, `cipo_oe` high only in data phase.
- 15-bit write frame to addr 0 → `regs` unchanged, one `frame_err` pulse, no `wr_strobe`. Repeat with a 17-bit frame → same result.
- Write 0xFF to addr 0x10 → no register change, `frame_err` pulse. Read addr 0x10 → `cipo` all zeros.
- Assert `rst_n`=0 after 9 bits of a write to addr 1 → all `regs` 0, FSM IDLE, no strobe. A following valid frame commits normally.
- Toggle `sclk` with `ncs` high, and raise `ncs` coincident with the 16th `sclk` rise → no register change, and `frame_err` pulses for the 15-bit count.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Package for the SPI register bank.
// Holds the FSM state encoding, the R/W bit encoding and helpers that derive
// the frame length and the bit-counter width from the field widths.
package spi_reg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   // R/W bit + address + data
   function automatic int frame_w(input int addr_w, input int data_w);
      return 1 + addr_w + data_w;
   endfunction

   // Counter must hold FRAME_W+1 (saturation value marking an overlength frame)
   function automatic int cnt_w(input int addr_w, input int data_w);
      return $clog2(frame_w(addr_w, data_w) + 2);
   endfunction

endpackage

// File: rtl/spi_reg_bank_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for an asynchronous pin plus a
// registered previous value used for edge detection.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   i_async    : asynchronous pin
//   level      : synchronised level (SYNC_STAGES clk edges after the pin)
//   rise, fall : one-cycle registered edge pulses (one edge after level)
// All flops reset to 0, so a pin that sits high through reset produces a
// single rise after reset; consumers ignore that when no frame is open.
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   r_rise;
   logic                   r_fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
         r_prev <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= r_sync[SYNC_STAGES-1];
         r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
         r_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
      end
   end

   assign level = r_sync[SYNC_STAGES-1];
   assign rise  = r_rise;
   assign fall  = r_fall;

endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 peripheral exposing NUM_REGS read/write registers.
// All SPI pins are oversampled in the clk domain; nothing runs on sclk.
// Frame (MSB first): R/W bit, ADDR_W address bits, DATA_W data bits.
// Ports:
//   clk, rst_n         : system clock, async active-low reset
//   sclk, ncs, copi    : SPI pins (asynchronous)
//   cipo, cipo_oe      : read data out and its pad enable
//   regs               : flattened bank, reg k at [k*DATA_W +: DATA_W]
//   wr_strobe, wr_addr : one-cycle commit pulse and the committed address
//   frame_err          : one-cycle pulse for a rejected frame
//   dbg_state          : current FSM state (spi_reg_pkg::state_t encoding)
// Handshake: wr_strobe/frame_err are single-cycle valid pulses with no ready;
// wr_addr and regs are stable from the strobe cycle until the next commit.
module spi_reg_bank
   import spi_reg_pkg::*;
#(
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 8,
   parameter int NUM_REGS    = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sclk,
   input  logic                       ncs,
   input  logic                       copi,
   output logic                       cipo,
   output logic                       cipo_oe,
   output logic [NUM_REGS*DATA_W-1:0] regs,
   output logic                       wr_strobe,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic                       frame_err,
   output logic [1:0]                 dbg_state
);

   localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
   localparam int CNT_W   = cnt_w(ADDR_W, DATA_W);
   localparam logic [CNT_W-1:0]  CNT_FRAME    = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0]  CNT_SAT      = CNT_W'(FRAME_W + 1);
   localparam logic [CNT_W-1:0]  CNT_HDR_LAST = CNT_W'(ADDR_W);
   localparam logic [ADDR_W:0]   REGS_LIM     = (ADDR_W+1)'(NUM_REGS);

   logic w_sclk_rise, w_sclk_fall, w_sclk_level;
   logic w_ncs_rise, w_ncs_fall, w_ncs_level;
   logic w_copi, w_copi_rise, w_copi_fall;
   logic w_unused_edges;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .i_async(sclk),
      .level(w_sclk_level), .rise(w_sclk_rise), .fall(w_sclk_fall));
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
      .clk(clk), .rst_n(rst_n), .i_async(ncs),
      .level(w_ncs_level), .rise(w_ncs_rise), .fall(w_ncs_fall));
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
      .clk(clk), .rst_n(rst_n), .i_async(copi),
      .level(w_copi), .rise(w_copi_rise), .fall(w_copi_fall));

   assign w_unused_edges = w_sclk_level ^ w_copi_rise ^ w_copi_fall;

   state_t                r_state, w_next_state;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic [FRAME_W-1:0]    r_shift;
   logic                  r_rw;
   logic [ADDR_W-1:0]     r_addr;
   logic [DATA_W-1:0]     r_tx;
   logic                  r_skip_fall;
   logic [DATA_W-1:0]     r_regs [NUM_REGS];
   logic                  r_wr_strobe;
   logic [ADDR_W-1:0]     r_wr_addr;
   logic                  r_frame_err;

   logic                  w_sample;
   logic                  w_hdr_done;
   logic [ADDR_W-1:0]     w_hdr_addr;
   logic [DATA_W-1:0]     w_rd_data;
   logic                  w_addr_ok;

   // ncs level is already high one cycle before its rise pulse, so an sclk
   // edge arriving with the ncs rise is always dropped.
   assign w_sample   = w_sclk_rise && !w_ncs_level && !w_ncs_rise && (r_state != ST_IDLE);
   assign w_hdr_done = w_sample && (r_state == ST_CMD) && (r_bit_cnt == CNT_HDR_LAST);
   // Address as it will be once the current (last header) bit is shifted in
   assign w_hdr_addr = {r_shift[ADDR_W-2:0], w_copi};
   assign w_addr_ok  = {1'b0, r_addr} < REGS_LIM;

   always_comb begin
      w_rd_data = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (w_hdr_addr == ADDR_W'(k)) w_rd_data = r_regs[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      if (w_ncs_rise) begin
         w_next_state = ST_IDLE;
      end else if (w_ncs_fall) begin
         w_next_state = ST_CMD;
      end else begin
         case (r_state)
            ST_IDLE: w_next_state = ST_IDLE;
            ST_CMD:  if (w_hdr_done) w_next_state = ST_DATA;
            ST_DATA: w_next_state = ST_DATA;
            default: w_next_state = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_rw        <= RW_READ;
         r_addr      <= '0;
         r_tx        <= '0;
         r_skip_fall <= 1'b0;
         r_wr_strobe <= 1'b0;
         r_wr_addr   <= '0;
         r_frame_err <= 1'b0;
         for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
      end else begin
         r_wr_strobe <= 1'b0;
         r_frame_err <= 1'b0;
         if (w_ncs_fall) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= '0;
         end else if (w_ncs_rise) begin
            r_tx <= '0;
            // A zero count means no frame was open (e.g. reset mid-frame).
            if (r_bit_cnt != '0) begin
               if (r_bit_cnt == CNT_FRAME && w_addr_ok) begin
                  if (r_rw == RW_WRITE) begin
                     for (int k = 0; k < NUM_REGS; k++) begin
                        if (r_addr == ADDR_W'(k)) r_regs[k] <= r_shift[DATA_W-1:0];
                     end
                     r_wr_strobe <= 1'b1;
                     r_wr_addr   <= r_addr;
                  end
               end else begin
                  r_frame_err <= 1'b1;
               end
            end
            r_bit_cnt <= '0;
         end else if (w_sample) begin
            r_shift <= {r_shift[FRAME_W-2:0], w_copi};
            if (r_bit_cnt != CNT_SAT) r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_hdr_done) begin
               r_rw        <= r_shift[ADDR_W-1];
               r_addr      <= w_hdr_addr;
               r_tx        <= w_rd_data;
               r_skip_fall <= 1'b1;
            end
         end else if (w_sclk_fall && r_state == ST_DATA && r_rw == RW_READ) begin
            // The fall right after the last header bit would discard the MSB
            // before the controller samples it, so it is skipped.
            if (r_skip_fall) r_skip_fall <= 1'b0;
            else             r_tx <= {r_tx[DATA_W-2:0], 1'b0};
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
      assign regs[g*DATA_W +: DATA_W] = r_regs[g];
   end

   assign cipo_oe   = (r_state == ST_DATA) && (r_rw == RW_READ);
   assign cipo      = cipo_oe & r_tx[DATA_W-1];
   assign wr_strobe = r_wr_strobe;
   assign wr_addr   = r_wr_addr;
   assign frame_err = r_frame_err;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_reg_bank.sv
module tb_spi_reg_bank;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sclk = 1'b0;
   logic        ncs = 1'b1;
   logic        copi = 1'b0;
   logic        cipo, cipo_oe, wr_strobe, frame_err;
   logic [39:0] regs;
   logic [6:0]  wr_addr;
   logic [1:0]  dbg_state;

   int errors = 0;
   int checks = 0;

   // Event word: {is_err, addr[6:0], data[7:0]}
   logic [15:0] exp_q[$];
   logic [7:0]  rd_exp_q[$];
   logic [39:0] exp_regs = '0;

   logic [7:0]  rd_sh = '0;
   int          rd_n = 0;

   spi_reg_bank dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .ncs(ncs), .copi(copi),
      .cipo(cipo), .cipo_oe(cipo_oe), .regs(regs), .wr_strobe(wr_strobe),
      .wr_addr(wr_addr), .frame_err(frame_err), .dbg_state(dbg_state));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Event monitor: every strobe/err cycle must match the head of exp_q
   always @(negedge clk) begin
      if (rst_n && (wr_strobe || frame_err)) begin
         logic [15:0] act;
         act = {frame_err, 15'h0};
         if (wr_strobe) act = act | {1'b0, wr_addr, regs[int'(wr_addr)*8 +: 8]};
         if (exp_q.size() == 0) check("unexpected_event", {48'h0, act}, 64'hFFFF);
         else check("event", {48'h0, act}, {48'h0, exp_q.pop_front()});
      end
   end

   // Read monitor: controller samples cipo on sclk rising pin edges
   always @(posedge sclk) begin
      if (cipo_oe) begin
         rd_sh = {rd_sh[6:0], cipo};
         rd_n++;
         if (rd_n == 8) begin
            rd_n = 0;
            if (rd_exp_q.size() == 0) check("unexpected_read", {56'h0, rd_sh}, 64'h1FF);
            else check("read_data", {56'h0, rd_sh}, {56'h0, rd_exp_q.pop_front()});
         end
      end
   end

   task automatic half();
      repeat (8) @(negedge clk);
   endtask

   task automatic push_wr(input logic [6:0] a, input logic [7:0] d);
      exp_q.push_back({1'b0, a, d});
      exp_regs[int'(a)*8 +: 8] = d;
   endtask

   task automatic push_err();
      exp_q.push_back(16'h8000);
   endtask

   // coinc: ncs rises together with the last sclk rise
   task automatic spi_xfer(input logic [31:0] word, input int nbits, input bit is_rd, input bit coinc);
      ncs = 1'b0;
      half();
      for (int i = nbits - 1; i >= 0; i--) begin
         copi = word[i];
         half();
         if (coinc && i == 0) begin
            sclk = 1'b1;
            ncs  = 1'b1;
         end else begin
            sclk = 1'b1;
            if (is_rd) check("cipo_oe_phase", {63'h0, cipo_oe}, {63'h0, (nbits - 1 - i) >= 8});
            half();
            sclk = 1'b0;
         end
      end
      half();
      if (coinc) sclk = 1'b0;
      ncs  = 1'b1;
      copi = 1'b0;
      half();
      half();
   endtask

   task automatic check_regs(input string name);
      check(name, {24'h0, regs}, {24'h0, exp_regs});
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (5) @(negedge clk);
      check("rst_regs", {24'h0, regs}, 64'h0);
      check("rst_outs", {58'h0, cipo, cipo_oe, wr_strobe, frame_err, dbg_state},
            {58'h0, 6'b0});
      check("rst_wr_addr", {57'h0, wr_addr}, 64'h0);
      rst_n = 1'b1;
      half();

      // Write 0xA5 to addr 4, then read it back (last implemented register)
      push_wr(7'd4, 8'hA5);
      spi_xfer(32'h84A5, 16, 1'b0, 1'b0);
      check_regs("wr_a5_addr4");
      rd_exp_q.push_back(8'hA5);
      spi_xfer(32'h0400, 16, 1'b1, 1'b0);

      // Write 0x3C to addr 2, read it back
      push_wr(7'd2, 8'h3C);
      spi_xfer(32'h823C, 16, 1'b0, 1'b0);
      check_regs("wr_3c_addr2");
      rd_exp_q.push_back(8'h3C);
      spi_xfer(32'h0200, 16, 1'b1, 1'b0);
      check("oe_after_read", {62'h0, cipo_oe, cipo}, 64'h0);

      // 15-bit and 17-bit write frames to addr 0
      push_err();
      spi_xfer(32'h403B, 15, 1'b0, 1'b0);
      check_regs("short_frame");
      push_err();
      spi_xfer(32'h100EF, 17, 1'b0, 1'b0);
      check_regs("long_frame");

      // Out-of-range write and read
      push_err();
      spi_xfer(32'h90FF, 16, 1'b0, 1'b0);
      check_regs("oor_write");
      push_err();
      rd_exp_q.push_back(8'h00);
      spi_xfer(32'h1000, 16, 1'b1, 1'b0);

      // Reset after 9 bits of a write to addr 1
      ncs = 1'b0;
      half();
      for (int i = 8; i >= 0; i--) begin
         logic [8:0] part;
         part = 9'h102;
         copi = part[i];
         half();
         sclk = 1'b1;
         half();
         sclk = 1'b0;
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      exp_regs = '0;
      check("mid_rst_state", {62'h0, dbg_state}, 64'h0);
      check_regs("mid_rst_regs");
      rst_n = 1'b1;
      half();
      ncs = 1'b1;
      copi = 1'b0;
      half();
      half();
      check_regs("after_rst_abort");
      push_wr(7'd1, 8'h66);
      spi_xfer(32'h8166, 16, 1'b0, 1'b0);
      check_regs("after_rst_commit");

      // sclk toggling with ncs high has no effect
      for (int i = 0; i < 4; i++) begin
         sclk = 1'b1;
         half();
         sclk = 1'b0;
         half();
      end
      check_regs("sclk_ncs_high");

      // ncs rise coincident with 16th sclk rise: counted as 15 bits
      push_err();
      spi_xfer(32'h8399, 16, 1'b0, 1'b1);
      check_regs("coinc_edge");

      for (int i = 0; i < 200 && (exp_q.size() != 0 || rd_exp_q.size() != 0); i++)
         @(negedge clk);
      check("events_drained", 64'(exp_q.size()), 64'h0);
      check("reads_drained", 64'(rd_exp_q.size()), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
